sa_rdata_channel: RTL and testbench
===================================

SA_RDATA_CHANNEL -- requirements
Module: sa_RDATA_channel

Interface
REQ-001 SHALL have parameter MST_AMT, default 3: number of masters served.
REQ-002 SHALL have parameter OUTSTANDING_AMT, default 8: order-FIFO depth, i.e. outstanding read bursts.
REQ-003 SHALL have parameter MST_ID_W, default $clog2(MST_AMT): master ID width.
REQ-004 SHALL have parameter DATA_WIDTH, default 32: RDATA width.
REQ-005 SHALL have parameter RESP_W, default 2: RRESP width.
REQ-006 SHALL have parameter TRANS_DATA_LEN_W, default 3: ARLEN width.
REQ-007 SHALL have port ACLK_i  in  1  clock; one clock domain.
REQ-008 SHALL have port ARESETn_i  in  1  reset, synchronous, active-low.
REQ-009 SHALL have port AR_mst_id_i  in  MST_ID_W  ID of the master whose AR was granted.
REQ-010 SHALL have port AR_AxLEN_i  in  TRANS_DATA_LEN_W  ARLEN of the granted AR.
REQ-011 SHALL have port AR_fifo_order_wr_en_i  in  1  push {mst_id, AxLEN} into the order FIFO.
REQ-012 SHALL have port AR_stall_o  out  1  order FIFO full; stalls the AR channel.
REQ-013 SHALL have port s_RDATA_i / s_RRESP_i / s_RLAST_i / s_RVALID_i  in  DATA_WIDTH/RESP_W/1/1  slave R channel.
REQ-014 SHALL have port s_RREADY_o  out  1  ready to the slave.
REQ-015 SHALL have port dsp_RDATA_o / dsp_RRESP_o / dsp_RLAST_o  out  DATA_WIDTH*MST_AMT / RESP_W*MST_AMT / MST_AMT  per-master R payload.
REQ-016 SHALL have port dsp_RVALID_o  out  MST_AMT  per-master valid, at most one bit set.
REQ-017 SHALL have port dsp_RREADY_i  in  MST_AMT  per-master ready.
REQ-018 SHALL have port rlast_err_o  out  1  sticky RLAST-mismatch flag (see Configuration).

Function
REQ-019 SHALL hold {mst_id, AxLEN} in an OUTSTANDING_AMT-deep order FIFO, written on AR_fifo_order_wr_en_i; AR_stall_o = FIFO full.
REQ-020 SHALL route every beat to the master at the order-FIFO head; s_RREADY_o = 0 while the order FIFO is empty.
REQ-021 SHALL register each beat in one output stage: a beat accepted at edge N is visible on dsp_* after edge N (1-cycle latency).
REQ-022 SHALL drive s_RREADY_o = ~order_empty & (~out_valid | dsp_RREADY_i[out_id]), giving full throughput, one beat per cycle.
REQ-023 SHALL hold the output payload and valid stable while the selected dsp_RREADY_i is low.
REQ-024 SHALL drive the payload of every non-selected master to 0 and its valid to 0.
REQ-025 SHALL keep a beat counter that increments on each slave handshake, returns to 0 when it equals head AxLEN, and never wraps past AxLEN.
REQ-026 SHALL drive dsp_RLAST_o from the counter: asserted when counter == head AxLEN.
REQ-027 SHALL pop the order FIFO on the last-beat slave handshake, so the next burst routes from the following cycle.
REQ-028 SHALL handle a push and a pop in the same cycle without loss; a push while full is ignored (AR_stall_o must prevent it).
REQ-029 SHALL accept AxLEN = 0 as a single-beat burst: RLAST on the first beat, pop immediately.

Reset
REQ-030 SHALL, on ARESETn_i low at a clock edge, empty the order FIFO, clear the counter, and drive dsp_RVALID_o = 0, dsp_RDATA_o = 0, dsp_RRESP_o = 0, dsp_RLAST_o = 0, rlast_err_o = 0, AR_stall_o = 0 and s_RREADY_o = 0.
REQ-031 SHALL discard any in-flight beat when reset is asserted mid-burst; after reset release the first beat routes to a newly pushed head.

Configuration
REQ-032 SHALL, with macro SA_RDATA_RLAST_CHECK_EN defined, compare s_RLAST_i against the counter-derived last on each slave handshake and set rlast_err_o on mismatch; the flag is sticky until reset.
REQ-033 SHALL, without SA_RDATA_RLAST_CHECK_EN, ignore s_RLAST_i and tie rlast_err_o to 0; routing is identical in both builds.

Verification
REQ-034 SHALL cover: push {id=2, len=3}, slave sends 4 beats D0..D3 back-to-back, master 2 ready -> dsp_RVALID_o = 3'b100 for 4 cycles, RLAST on D3 only, order FIFO empty afterwards.
REQ-035 SHALL cover: push {0,1} then {1,0}, continuous slave beats -> 2 beats to master 0 then 1 beat to master 1 with RLAST, no bubble between bursts.
REQ-036 SHALL cover: master 0 ready held low for 5 cycles mid-burst -> payload stable, s_RREADY_o = 0 after one beat is buffered, burst resumes without loss.
REQ-037 SHALL cover: 8 pushes with no R beats -> AR_stall_o = 1; one burst completed with a same-cycle push -> AR_stall_o stays 1 and the count remains 8.
REQ-038 SHALL cover: with SA_RDATA_RLAST_CHECK_EN, len=2 and s_RLAST_i on beat 1 -> rlast_err_o = 1, held until ARESETn_i = 0.
REQ-039 SHALL cover: reset asserted at beat 2 of a len=7 burst -> all outputs 0 next cycle, s_RREADY_o = 0 until a new push.

Source files
------------

// File: rtl/sa_rdata_channel.sv
// sa_rdata_channel
//   Routes the read-data (R) beats from one shared slave to the master that
//   issued the corresponding AR. Granted ARs are recorded as {mst_id, AxLEN}
//   in an in-order FIFO. Each slave beat goes to the master at the FIFO head.
//   A beat counter derives RLAST from the recorded AxLEN and pops the head on
//   the final beat. One registered output stage gives 1-cycle latency and
//   full throughput.
//
// Optional feature (compile-time macro SA_RDATA_RLAST_CHECK_EN):
//   when defined, the slave's RLAST is compared against the counter-derived
//   last on every handshake, and a mismatch sets the sticky rlast_err_o.
//   When undefined, s_RLAST_i is ignored and rlast_err_o is tied to 0.
//
// Ports
//   ACLK_i, ARESETn_i        clock; synchronous active-low reset
//   AR_mst_id_i, AR_AxLEN_i  id / ARLEN of the granted AR
//   AR_fifo_order_wr_en_i    push {id, len} into the order FIFO
//   AR_stall_o               order FIFO full
//   s_R*_i, s_RREADY_o       slave R channel
//   dsp_R*_o, dsp_RREADY_i   per-master R channels (packed, master m at slice m)
//   rlast_err_o              sticky RLAST mismatch flag
module sa_rdata_channel #(
    parameter int MST_AMT          = 3,
    parameter int OUTSTANDING_AMT  = 8,
    parameter int MST_ID_W         = $clog2(MST_AMT),
    parameter int DATA_WIDTH       = 32,
    parameter int RESP_W           = 2,
    parameter int TRANS_DATA_LEN_W = 3
) (
    input  logic                          ACLK_i,
    input  logic                          ARESETn_i,
    input  logic [MST_ID_W-1:0]           AR_mst_id_i,
    input  logic [TRANS_DATA_LEN_W-1:0]   AR_AxLEN_i,
    input  logic                          AR_fifo_order_wr_en_i,
    output logic                          AR_stall_o,
    input  logic [DATA_WIDTH-1:0]         s_RDATA_i,
    input  logic [RESP_W-1:0]             s_RRESP_i,
    input  logic                          s_RLAST_i,
    input  logic                          s_RVALID_i,
    output logic                          s_RREADY_o,
    output logic [DATA_WIDTH*MST_AMT-1:0] dsp_RDATA_o,
    output logic [RESP_W*MST_AMT-1:0]     dsp_RRESP_o,
    output logic [MST_AMT-1:0]            dsp_RLAST_o,
    output logic [MST_AMT-1:0]            dsp_RVALID_o,
    input  logic [MST_AMT-1:0]            dsp_RREADY_i,
    output logic                          rlast_err_o
);

    localparam int PTR_W = (OUTSTANDING_AMT > 1) ? $clog2(OUTSTANDING_AMT) : 1;
    localparam int CNT_W = $clog2(OUTSTANDING_AMT + 1);

    logic [MST_ID_W-1:0]         ord_id  [OUTSTANDING_AMT];
    logic [TRANS_DATA_LEN_W-1:0] ord_len [OUTSTANDING_AMT];
    logic [PTR_W-1:0]            wr_ptr;
    logic [PTR_W-1:0]            rd_ptr;
    logic [CNT_W-1:0]            ord_cnt;
    logic                        order_empty;
    logic                        order_full;
    logic                        push;
    logic                        pop;
    logic [MST_ID_W-1:0]         head_id;
    logic [TRANS_DATA_LEN_W-1:0] head_len;

    logic [TRANS_DATA_LEN_W-1:0] beat_cnt;
    logic                        beat_last;
    logic                        s_hs;
    logic                        out_ready;

    logic                        vld_p1;
    logic [MST_ID_W-1:0]         id_p1;
    logic [DATA_WIDTH-1:0]       data_p1;
    logic [RESP_W-1:0]           resp_p1;
    logic                        last_p1;

    // Pointer increment with explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(OUTSTANDING_AMT - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign order_empty = (ord_cnt == '0);
    assign order_full  = (ord_cnt == CNT_W'(OUTSTANDING_AMT));
    assign AR_stall_o  = order_full;
    assign head_id     = ord_id[rd_ptr];
    assign head_len    = ord_len[rd_ptr];

    assign s_RREADY_o  = ~order_empty & (~vld_p1 | out_ready);
    assign s_hs        = s_RVALID_i & s_RREADY_o;
    assign beat_last   = (beat_cnt == head_len);
    assign pop         = s_hs & beat_last;
    // A push while full is accepted only when the head pops in the same
    // cycle, so occupancy stays at the maximum instead of dropping the AR.
    assign push        = AR_fifo_order_wr_en_i & (~order_full | pop);

    always_ff @(posedge ACLK_i) begin
        if (!ARESETn_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ord_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   ord_cnt <= ord_cnt + CNT_W'(1);
                2'b01:   ord_cnt <= ord_cnt - CNT_W'(1);
                default: ord_cnt <= ord_cnt;
            endcase
        end
    end

    always_ff @(posedge ACLK_i) begin
        if (push) begin
            ord_id[wr_ptr]  <= AR_mst_id_i;
            ord_len[wr_ptr] <= AR_AxLEN_i;
        end
    end

    // Beat counter: returns to 0 on the last beat, so it never passes AxLEN.
    always_ff @(posedge ACLK_i) begin
        if (!ARESETn_i) begin
            beat_cnt <= '0;
        end else if (s_hs) begin
            beat_cnt <= beat_last ? '0 : beat_cnt + TRANS_DATA_LEN_W'(1);
        end
    end

    // ---- stage p1: registered output beat ----
    always_ff @(posedge ACLK_i) begin
        if (!ARESETn_i) begin
            vld_p1 <= 1'b0;
            id_p1  <= '0;
        end else if (s_hs) begin
            vld_p1 <= 1'b1;
            id_p1  <= head_id;
        end else if (out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    // Payload is not reset; the output mux forces it to 0 whenever vld_p1 is low.
    always_ff @(posedge ACLK_i) begin
        if (s_hs) begin
            data_p1 <= s_RDATA_i;
            resp_p1 <= s_RRESP_i;
            last_p1 <= beat_last;
        end
    end

    always_comb begin
        dsp_RDATA_o  = '0;
        dsp_RRESP_o  = '0;
        dsp_RLAST_o  = '0;
        dsp_RVALID_o = '0;
        out_ready    = 1'b0;
        for (int m = 0; m < MST_AMT; m++) begin
            if (id_p1 == MST_ID_W'(m)) begin
                out_ready = dsp_RREADY_i[m];
                if (vld_p1) begin
                    dsp_RVALID_o[m]                          = 1'b1;
                    dsp_RDATA_o[m*DATA_WIDTH +: DATA_WIDTH]  = data_p1;
                    dsp_RRESP_o[m*RESP_W +: RESP_W]          = resp_p1;
                    dsp_RLAST_o[m]                           = last_p1;
                end
            end
        end
    end

`ifdef SA_RDATA_RLAST_CHECK_EN
    logic rlast_err;

    always_ff @(posedge ACLK_i) begin
        if (!ARESETn_i) begin
            rlast_err <= 1'b0;
        end else if (s_hs && (s_RLAST_i != beat_last)) begin
            rlast_err <= 1'b1;
        end
    end

    assign rlast_err_o = rlast_err;
`else
    logic unused_rlast;

    assign unused_rlast = s_RLAST_i;
    assign rlast_err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_sa_rdata_channel.sv
`timescale 1ns/1ps
module tb_sa_rdata_channel;

    localparam int MST_AMT = 3;
    localparam int DW      = 32;
    localparam int RW      = 2;
    localparam int LW      = 3;
    localparam int IW      = 2;

    logic                   ACLK_i = 1'b0;
    logic                   ARESETn_i;
    logic [IW-1:0]          AR_mst_id_i;
    logic [LW-1:0]          AR_AxLEN_i;
    logic                   AR_fifo_order_wr_en_i;
    logic                   AR_stall_o;
    logic [DW-1:0]          s_RDATA_i;
    logic [RW-1:0]          s_RRESP_i;
    logic                   s_RLAST_i;
    logic                   s_RVALID_i;
    logic                   s_RREADY_o;
    logic [DW*MST_AMT-1:0]  dsp_RDATA_o;
    logic [RW*MST_AMT-1:0]  dsp_RRESP_o;
    logic [MST_AMT-1:0]     dsp_RLAST_o;
    logic [MST_AMT-1:0]     dsp_RVALID_o;
    logic [MST_AMT-1:0]     dsp_RREADY_i;
    logic                   rlast_err_o;

    always #5 ACLK_i = ~ACLK_i;

    sa_rdata_channel #(
        .MST_AMT(MST_AMT), .OUTSTANDING_AMT(8), .MST_ID_W(IW),
        .DATA_WIDTH(DW), .RESP_W(RW), .TRANS_DATA_LEN_W(LW)
    ) dut (
        .ACLK_i(ACLK_i), .ARESETn_i(ARESETn_i),
        .AR_mst_id_i(AR_mst_id_i), .AR_AxLEN_i(AR_AxLEN_i),
        .AR_fifo_order_wr_en_i(AR_fifo_order_wr_en_i), .AR_stall_o(AR_stall_o),
        .s_RDATA_i(s_RDATA_i), .s_RRESP_i(s_RRESP_i), .s_RLAST_i(s_RLAST_i),
        .s_RVALID_i(s_RVALID_i), .s_RREADY_o(s_RREADY_o),
        .dsp_RDATA_o(dsp_RDATA_o), .dsp_RRESP_o(dsp_RRESP_o), .dsp_RLAST_o(dsp_RLAST_o),
        .dsp_RVALID_o(dsp_RVALID_o), .dsp_RREADY_i(dsp_RREADY_i), .rlast_err_o(rlast_err_o)
    );

    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
        logic [RW-1:0] resp;
        logic          last;
    } beat_t;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [LW-1:0] len;
    } ord_t;

    beat_t exp_q[$];
    beat_t obs_q[$];
    ord_t  mdl_q[$];
    int    mdl_cnt;
    int    total;
    int    bad;
    int    rlast_force;

    logic                  smp_hs;
    logic                  smp_rready;
    logic                  smp_stall;
    logic                  smp_err;
    logic [MST_AMT-1:0]    smp_vld;
    logic [MST_AMT-1:0]    smp_last;
    logic [DW*MST_AMT-1:0] smp_data;
    logic [RW*MST_AMT-1:0] smp_resp;

    // One clock: sample at the falling edge, update the reference order model
    // and scoreboard, then move to 1 ns after the next rising edge.
    task automatic cycle();
        beat_t b;
        ord_t  o;
        @(negedge ACLK_i);
        smp_vld    = dsp_RVALID_o;
        smp_last   = dsp_RLAST_o;
        smp_data   = dsp_RDATA_o;
        smp_resp   = dsp_RRESP_o;
        smp_rready = s_RREADY_o;
        smp_stall  = AR_stall_o;
        smp_err    = rlast_err_o;
        smp_hs     = s_RVALID_i & s_RREADY_o;
        if (!ARESETn_i) begin
            exp_q.delete();
            obs_q.delete();
            mdl_q.delete();
            mdl_cnt = 0;
        end else begin
            for (int m = 0; m < MST_AMT; m++) begin
                if (dsp_RVALID_o[m] && dsp_RREADY_i[m]) begin
                    b.id   = IW'(m);
                    b.data = dsp_RDATA_o[m*DW +: DW];
                    b.resp = dsp_RRESP_o[m*RW +: RW];
                    b.last = dsp_RLAST_o[m];
                    obs_q.push_back(b);
                end
            end
            if (smp_hs) begin
                b.data = s_RDATA_i;
                b.resp = s_RRESP_i;
                if (mdl_q.size() > 0) begin
                    b.id   = mdl_q[0].id;
                    b.last = (mdl_cnt == int'(mdl_q[0].len));
                    if (b.last) begin
                        void'(mdl_q.pop_front());
                        mdl_cnt = 0;
                    end else begin
                        mdl_cnt++;
                    end
                end else begin
                    b.id   = 'x;
                    b.last = 1'bx;
                end
                exp_q.push_back(b);
            end
            if (AR_fifo_order_wr_en_i && mdl_q.size() < 8) begin
                o.id  = AR_mst_id_i;
                o.len = AR_AxLEN_i;
                mdl_q.push_back(o);
            end
        end
        @(posedge ACLK_i);
        #1;
        if (smp_hs) begin
            s_RDATA_i = $urandom;
            s_RRESP_i = RW'($urandom);
        end
        if (rlast_force >= 0) begin
            s_RLAST_i = rlast_force[0];
        end else if (mdl_q.size() > 0) begin
            s_RLAST_i = (mdl_cnt == int'(mdl_q[0].len));
        end else begin
            s_RLAST_i = 1'b0;
        end
    endtask

    task automatic push_ar(input logic [IW-1:0] id, input logic [LW-1:0] len);
        AR_mst_id_i           = id;
        AR_AxLEN_i            = len;
        AR_fifo_order_wr_en_i = 1'b1;
        cycle();
        AR_fifo_order_wr_en_i = 1'b0;
    endtask

    task automatic drain(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < max_cycles; c++) begin
            s_RVALID_i = (mdl_q.size() > 0);
            cycle();
            if (mdl_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        s_RVALID_i = 1'b0;
        repeat (3) cycle();
    endtask

    task automatic test_reset();
        ARESETn_i             = 1'b0;
        s_RVALID_i            = 1'b1;
        AR_fifo_order_wr_en_i = 1'b1;
        AR_mst_id_i           = 2'd1;
        AR_AxLEN_i            = 3'd2;
        repeat (3) cycle();
        total += 7;
        if (smp_vld !== '0)    begin bad++; $display("FAIL reset_rvalid: got %b want 000", smp_vld); end
        if (smp_data !== '0)   begin bad++; $display("FAIL reset_rdata: got %h want 0", smp_data); end
        if (smp_resp !== '0)   begin bad++; $display("FAIL reset_rresp: got %h want 0", smp_resp); end
        if (smp_last !== '0)   begin bad++; $display("FAIL reset_rlast: got %b want 000", smp_last); end
        if (smp_err !== 1'b0)  begin bad++; $display("FAIL reset_rlast_err: got %b want 0", smp_err); end
        if (smp_stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", smp_stall); end
        if (smp_rready !== 1'b0) begin bad++; $display("FAIL reset_rready: got %b want 0", smp_rready); end
        AR_fifo_order_wr_en_i = 1'b0;
        ARESETn_i             = 1'b1;
        cycle();
        total++;
        if (smp_rready !== 1'b0) begin bad++; $display("FAIL empty_rready: got %b want 0", smp_rready); end
        s_RVALID_i = 1'b0;
        cycle();
    endtask

    task automatic test_single_burst();
        beat_t         e, o;
        logic [11:0]   vld_hist, last_hist;
        logic [1:0]    other_vld;
        logic [2*DW-1:0] other_data;
        vld_hist   = '0;
        last_hist  = '0;
        other_vld  = '0;
        other_data = '0;
        push_ar(2'd2, 3'd3);
        for (int c = 0; c < 12; c++) begin
            s_RVALID_i = (mdl_q.size() > 0);
            cycle();
            vld_hist[c]  = smp_vld[2];
            last_hist[c] = smp_last[2];
            other_vld    = other_vld | smp_vld[1:0];
            other_data   = other_data | smp_data[2*DW-1:0];
        end
        total += 4;
        if (vld_hist !== 12'h01E)   begin bad++; $display("FAIL burst4_valid_window: got %h want 01e", vld_hist); end
        if (last_hist !== 12'h010)  begin bad++; $display("FAIL burst4_rlast_pos: got %h want 010", last_hist); end
        if (other_vld !== 2'b00)    begin bad++; $display("FAIL burst4_other_valid: got %b want 00", other_vld); end
        if (other_data !== '0)      begin bad++; $display("FAIL burst4_other_payload: got %h want 0", other_data); end
        s_RVALID_i = 1'b1;
        cycle();
        s_RVALID_i = 1'b0;
        total++;
        if (smp_rready !== 1'b0) begin bad++; $display("FAIL burst4_fifo_empty_rready: got %b want 0", smp_rready); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL burst4_beat: got id=%0d data=%h resp=%0d last=%b want id=%0d data=%h resp=%0d last=%b",
                         o.id, o.data, o.resp, o.last, e.id, e.data, e.resp, e.last);
            end
        end
        total++;
        if (exp_q.size() != 0 || obs_q.size() != 0) begin
            bad++; $display("FAIL burst4_leftover: exp=%0d obs=%0d want 0/0", exp_q.size(), obs_q.size());
        end
    endtask

    task automatic test_back_to_back();
        beat_t       e, o;
        logic [17:0] vld_hist, last_hist;
        push_ar(2'd0, 3'd1);
        push_ar(2'd1, 3'd0);
        for (int c = 0; c < 6; c++) begin
            s_RVALID_i = (mdl_q.size() > 0);
            cycle();
            vld_hist[c*3 +: 3]  = smp_vld;
            last_hist[c*3 +: 3] = smp_last;
        end
        total += 2;
        if (vld_hist !== 18'h00448)  begin bad++; $display("FAIL b2b_valid_seq: got %h want 00448", vld_hist); end
        if (last_hist !== 18'h00440) begin bad++; $display("FAIL b2b_rlast_seq: got %h want 00440", last_hist); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL b2b_beat: got id=%0d data=%h resp=%0d last=%b want id=%0d data=%h resp=%0d last=%b",
                         o.id, o.data, o.resp, o.last, e.id, e.data, e.resp, e.last);
            end
        end
        total++;
        if (exp_q.size() != 0 || obs_q.size() != 0) begin
            bad++; $display("FAIL b2b_leftover: exp=%0d obs=%0d want 0/0", exp_q.size(), obs_q.size());
        end
    endtask

    task automatic test_backpressure();
        beat_t         e, o;
        logic [DW-1:0] d0;
        bit            ok;
        push_ar(2'd0, 3'd3);
        d0         = s_RDATA_i;
        s_RVALID_i = 1'b1;
        cycle();
        dsp_RREADY_i[0] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            s_RVALID_i = 1'b1;
            cycle();
            total += 2;
            if (smp_rready !== 1'b0) begin bad++; $display("FAIL bp_rready_low c%0d: got %b want 0", c, smp_rready); end
            if (smp_vld !== 3'b001 || smp_data[DW-1:0] !== d0) begin
                bad++; $display("FAIL bp_hold c%0d: got vld=%b data=%h want vld=001 data=%h", c, smp_vld, smp_data[DW-1:0], d0);
            end
        end
        dsp_RREADY_i[0] = 1'b1;
        drain(40, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL bp_drain_timeout: got pending=%0d want 0", mdl_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL bp_beat: got id=%0d data=%h resp=%0d last=%b want id=%0d data=%h resp=%0d last=%b",
                         o.id, o.data, o.resp, o.last, e.id, e.data, e.resp, e.last);
            end
        end
        total++;
        if (exp_q.size() != 0 || obs_q.size() != 0) begin
            bad++; $display("FAIL bp_leftover: exp=%0d obs=%0d want 0/0", exp_q.size(), obs_q.size());
        end
    endtask

    task automatic test_stall();
        beat_t e, o;
        bit    ok;
        s_RVALID_i = 1'b0;
        push_ar(2'd1, 3'd1);
        for (int i = 0; i < 7; i++) begin
            push_ar(2'd2, 3'd0);
        end
        total++;
        if (smp_stall !== 1'b0) begin bad++; $display("FAIL stall_at7: got %b want 0", smp_stall); end
        cycle();
        total++;
        if (smp_stall !== 1'b1) begin bad++; $display("FAIL stall_at8: got %b want 1", smp_stall); end
        s_RVALID_i = 1'b1;
        cycle();
        AR_mst_id_i           = 2'd0;
        AR_AxLEN_i            = 3'd0;
        AR_fifo_order_wr_en_i = 1'b1;
        cycle();
        AR_fifo_order_wr_en_i = 1'b0;
        s_RVALID_i            = 1'b0;
        cycle();
        total += 2;
        if (smp_stall !== 1'b1) begin bad++; $display("FAIL stall_pop_push: got %b want 1", smp_stall); end
        if (mdl_q.size() != 8) begin bad++; $display("FAIL stall_model_count: got %0d want 8", mdl_q.size()); end
        s_RVALID_i = 1'b1;
        cycle();
        s_RVALID_i = 1'b0;
        cycle();
        total++;
        if (smp_stall !== 1'b0) begin bad++; $display("FAIL stall_release: got %b want 0", smp_stall); end
        drain(60, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL stall_drain_timeout: got pending=%0d want 0", mdl_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL stall_beat: got id=%0d data=%h resp=%0d last=%b want id=%0d data=%h resp=%0d last=%b",
                         o.id, o.data, o.resp, o.last, e.id, e.data, e.resp, e.last);
            end
        end
        total++;
        if (exp_q.size() != 0 || obs_q.size() != 0) begin
            bad++; $display("FAIL stall_leftover: exp=%0d obs=%0d want 0/0", exp_q.size(), obs_q.size());
        end
    endtask

    task automatic test_rlast_check();
        beat_t e, o;
        logic  exp_err;
`ifdef SA_RDATA_RLAST_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        push_ar(2'd1, 3'd2);
        rlast_force = 0;
        s_RLAST_i   = 1'b0;
        s_RVALID_i  = 1'b1;
        cycle();
        rlast_force = 1;
        s_RLAST_i   = 1'b1;
        cycle();
        total++;
        if (smp_err !== 1'b0) begin bad++; $display("FAIL rlast_err_early: got %b want 0", smp_err); end
        cycle();
        rlast_force = -1;
        s_RVALID_i  = 1'b0;
        total++;
        if (smp_err !== exp_err) begin bad++; $display("FAIL rlast_err_set: got %b want %b", smp_err, exp_err); end
        repeat (4) cycle();
        total++;
        if (smp_err !== exp_err) begin bad++; $display("FAIL rlast_err_sticky: got %b want %b", smp_err, exp_err); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL rlast_beat: got id=%0d data=%h resp=%0d last=%b want id=%0d data=%h resp=%0d last=%b",
                         o.id, o.data, o.resp, o.last, e.id, e.data, e.resp, e.last);
            end
        end
        total++;
        if (exp_q.size() != 0 || obs_q.size() != 0) begin
            bad++; $display("FAIL rlast_leftover: exp=%0d obs=%0d want 0/0", exp_q.size(), obs_q.size());
        end
        ARESETn_i = 1'b0;
        cycle();
        ARESETn_i = 1'b1;
        cycle();
        total++;
        if (smp_err !== 1'b0) begin bad++; $display("FAIL rlast_err_cleared: got %b want 0", smp_err); end
    endtask

    task automatic test_reset_mid_burst();
        beat_t e, o;
        bit    ok;
        push_ar(2'd0, 3'd7);
        s_RVALID_i = 1'b1;
        cycle();
        cycle();
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL midrst_pre_beat: got id=%0d data=%h last=%b want id=%0d data=%h last=%b",
                         o.id, o.data, o.last, e.id, e.data, e.last);
            end
        end
        ARESETn_i = 1'b0;
        cycle();
        ARESETn_i = 1'b1;
        cycle();
        total += 4;
        if (smp_vld !== '0 || smp_last !== '0) begin
            bad++; $display("FAIL midrst_valid_last: got vld=%b last=%b want 000/000", smp_vld, smp_last);
        end
        if (smp_data !== '0 || smp_resp !== '0) begin
            bad++; $display("FAIL midrst_payload: got data=%h resp=%h want 0", smp_data, smp_resp);
        end
        if (smp_stall !== 1'b0 || smp_err !== 1'b0) begin
            bad++; $display("FAIL midrst_stall_err: got stall=%b err=%b want 0/0", smp_stall, smp_err);
        end
        if (smp_rready !== 1'b0) begin bad++; $display("FAIL midrst_rready: got %b want 0", smp_rready); end
        for (int c = 0; c < 3; c++) begin
            cycle();
            total++;
            if (smp_rready !== 1'b0) begin bad++; $display("FAIL midrst_rready_idle c%0d: got %b want 0", c, smp_rready); end
        end
        push_ar(2'd1, 3'd0);
        drain(20, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL midrst_drain_timeout: got pending=%0d want 0", mdl_q.size()); end
        total++;
        if (exp_q.size() != 1) begin bad++; $display("FAIL midrst_new_beats: got %0d want 1", exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL midrst_new_beat: got id=%0d data=%h resp=%0d last=%b want id=%0d data=%h resp=%0d last=%b",
                         o.id, o.data, o.resp, o.last, e.id, e.data, e.resp, e.last);
            end
        end
        total++;
        if (exp_q.size() != 0 || obs_q.size() != 0) begin
            bad++; $display("FAIL midrst_leftover: exp=%0d obs=%0d want 0/0", exp_q.size(), obs_q.size());
        end
    endtask

    initial begin
        total                 = 0;
        bad                   = 0;
        mdl_cnt               = 0;
        rlast_force           = -1;
        ARESETn_i             = 1'b0;
        AR_mst_id_i           = '0;
        AR_AxLEN_i            = '0;
        AR_fifo_order_wr_en_i = 1'b0;
        s_RDATA_i             = $urandom;
        s_RRESP_i             = RW'($urandom);
        s_RLAST_i             = 1'b0;
        s_RVALID_i            = 1'b0;
        dsp_RREADY_i          = '1;
        test_reset();
        test_single_burst();
        test_back_to_back();
        test_backpressure();
        test_stall();
        test_rlast_check();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
